// File: rtl/hpdcache_data_upsize_if.sv
// Handshake bundle between a narrow-beat producer and the wide-word FIFO consumer.
// The FIFO side takes the slave modport; the environment driving it takes master.
interface hpdcache_data_upsize_if #(
    parameter int unsigned WR_WIDTH = 16,
    parameter int unsigned RD_WIDTH = 64
);
    logic                w_i;
    logic                wlast_i;
    logic                wok_o;
    logic [WR_WIDTH-1:0] wdata_i;
    logic                r_i;
    logic                rok_o;
    logic [RD_WIDTH-1:0] rdata_o;

    modport master (
        output w_i, wlast_i, wdata_i, r_i,
        input  wok_o, rok_o, rdata_o
    );

    modport slave (
        input  w_i, wlast_i, wdata_i, r_i,
        output wok_o, rok_o, rdata_o
    );
endinterface

// File: rtl/hpdcache_data_upsize.sv
// Narrow-to-wide data FIFO: packs narrow write beats into wide entries, with
// early close via wlast_i zero-filling the beats that were never written.
module hpdcache_data_upsize #(
    parameter int unsigned WR_WIDTH = 16,
    parameter int unsigned RD_WIDTH = 64,
    parameter int unsigned DEPTH    = 2
) (
    input logic                  clk_i,
    input logic                  rst_i,
    hpdcache_data_upsize_if.slave bus
);
    localparam int unsigned WR_WORDS  = (WR_WIDTH > 0) ? RD_WIDTH / WR_WIDTH : 2;
    localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_WIDTH = (WR_WORDS > 2) ? $clog2(WR_WORDS) : 1;

    localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(DEPTH - 1);
    localparam logic [PTR_WIDTH:0]   USED_FULL = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(WR_WORDS - 1);

    if (WR_WIDTH == 0) begin : g_chk_wr_width
        $fatal(1, "hpdcache_data_upsize: WR_WIDTH must be > 0");
    end
    if (RD_WIDTH <= WR_WIDTH) begin : g_chk_rd_width
        $fatal(1, "hpdcache_data_upsize: RD_WIDTH must be > WR_WIDTH");
    end
    if (WR_WIDTH != 0 && (RD_WIDTH % WR_WIDTH) != 0) begin : g_chk_ratio
        $fatal(1, "hpdcache_data_upsize: RD_WIDTH must be a multiple of WR_WIDTH");
    end
    if (DEPTH == 0) begin : g_chk_depth
        $fatal(1, "hpdcache_data_upsize: DEPTH must be > 0");
    end

    logic [RD_WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wrptr_q;
    logic [PTR_WIDTH-1:0] rdptr_q;
    logic [PTR_WIDTH:0]   used_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic w_acc;
    logic r_acc;
    logic commit;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // used_q counts committed entries only, so the flags never see r_i or w_i
    assign bus.wok_o   = (used_q != USED_FULL);
    assign bus.rok_o   = (used_q != '0);
    assign bus.rdata_o = mem_q[rdptr_q];

    assign w_acc  = bus.w_i & bus.wok_o;
    assign r_acc  = bus.r_i & bus.rok_o;
    assign commit = w_acc & (bus.wlast_i | (cnt_q == CNT_LAST));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            used_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_acc) begin
                // first beat rewrites the whole entry so an early close leaves zeros above it
                if (cnt_q == '0) begin
                    mem_q[wrptr_q] <= RD_WIDTH'(bus.wdata_i);
                end else begin
                    mem_q[wrptr_q][int'(cnt_q)*WR_WIDTH +: WR_WIDTH] <= bus.wdata_i;
                end
            end

            if (commit) begin
                cnt_q   <= '0;
                wrptr_q <= ptr_inc(wrptr_q);
            end else if (w_acc) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (r_acc) begin
                rdptr_q <= ptr_inc(rdptr_q);
            end

            case ({commit, r_acc})
                2'b10:   used_q <= used_q + 1'b1;
                2'b01:   used_q <= used_q - 1'b1;
                default: used_q <= used_q;
            endcase
        end
    end
endmodule

// File: tb/tb_hpdcache_data_upsize.sv
// Directed and randomized checks of the upsizing FIFO against a queue-based model,
// exercised at DEPTH 2, 1 and 3 with 16-bit beats packed into 64-bit words.
module tb_hpdcache_data_upsize;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hpdcache_data_upsize_if #(.WR_WIDTH(16), .RD_WIDTH(64)) if_d2 ();
    hpdcache_data_upsize_if #(.WR_WIDTH(16), .RD_WIDTH(64)) if_d1 ();
    hpdcache_data_upsize_if #(.WR_WIDTH(16), .RD_WIDTH(64)) if_d3 ();

    hpdcache_data_upsize #(.WR_WIDTH(16), .RD_WIDTH(64), .DEPTH(2)) dut_d2 (
        .clk_i(clk), .rst_i(rst), .bus(if_d2.slave));
    hpdcache_data_upsize #(.WR_WIDTH(16), .RD_WIDTH(64), .DEPTH(1)) dut_d1 (
        .clk_i(clk), .rst_i(rst), .bus(if_d1.slave));
    hpdcache_data_upsize #(.WR_WIDTH(16), .RD_WIDTH(64), .DEPTH(3)) dut_d3 (
        .clk_i(clk), .rst_i(rst), .bus(if_d3.slave));

    virtual hpdcache_data_upsize_if #(.WR_WIDTH(16), .RD_WIDTH(64)) vif;

    int checks = 0;
    int fails  = 0;

    // reference model: committed wide words in order, plus the entry being filled
    logic [63:0] exp_q[$];
    logic [63:0] part;
    int          beat;
    int          depth;
    int          commits;
    int          pops;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        part    = '0;
        beat    = 0;
        commits = 0;
        pops    = 0;
    endtask

    task automatic idle_all();
        if_d2.w_i = 0; if_d2.wlast_i = 0; if_d2.wdata_i = '0; if_d2.r_i = 0;
        if_d1.w_i = 0; if_d1.wlast_i = 0; if_d1.wdata_i = '0; if_d1.r_i = 0;
        if_d3.w_i = 0; if_d3.wlast_i = 0; if_d3.wdata_i = '0; if_d3.r_i = 0;
    endtask

    task automatic use_dut(input int d);
        case (d)
            1:       vif = if_d1;
            3:       vif = if_d3;
            default: vif = if_d2;
        endcase
        depth   = d;
        commits = 0;
        pops    = 0;
    endtask

    // one clock: check outputs against the model, drive, update the model after the edge
    task automatic cycle(input logic w, input logic wl, input logic [15:0] d, input logic r);
        bit acc_w, acc_r;
        chk("rok", vif.rok_o, exp_q.size() != 0);
        chk("wok", vif.wok_o, exp_q.size() != depth);
        if (exp_q.size() != 0) chk("head", vif.rdata_o, exp_q[0]);
        vif.w_i     = w;
        vif.wlast_i = wl;
        vif.wdata_i = d;
        vif.r_i     = r;
        acc_w = w && (exp_q.size() != depth);
        acc_r = r && (exp_q.size() != 0);
        @(posedge clk);
        #1;
        vif.w_i = 0; vif.wlast_i = 0; vif.wdata_i = '0; vif.r_i = 0;
        if (acc_r) begin
            void'(exp_q.pop_front());
            pops++;
        end
        if (acc_w) begin
            if (beat == 0) part = '0;
            part[beat*16 +: 16] = d;
            if (beat == 3 || wl) begin
                exp_q.push_back(part);
                commits++;
                beat = 0;
            end else begin
                beat++;
            end
        end
        @(negedge clk);
    endtask

    task automatic write_entry(input logic [15:0] b0, b1, b2, b3);
        cycle(1, 0, b0, 0);
        cycle(1, 0, b1, 0);
        cycle(1, 0, b2, 0);
        cycle(1, 0, b3, 0);
    endtask

    task automatic stream(input int d);
        int n;
        logic w, wl, r;
        use_dut(d);
        n = 0;
        while ((commits < 7 || exp_q.size() != 0) && n < 1000) begin
            w  = (commits < 7) && ($urandom % 10 < 7);
            wl = ($urandom % 5 == 0);
            r  = ($urandom % 10 < 6);
            cycle(w, wl, 16'($urandom), r);
            n++;
        end
        chk($sformatf("stream_d%0d_commits", d), 64'(commits), 64'd7);
        chk($sformatf("stream_d%0d_pops", d), 64'(pops), 64'd7);
        chk($sformatf("stream_d%0d_rok", d), vif.rok_o, 1'b0);
    endtask

    initial begin
        idle_all();
        model_reset();
        use_dut(2);
        @(negedge clk);
        @(negedge clk);
        chk("reset_rok", vif.rok_o, 1'b0);
        chk("reset_wok", vif.wok_o, 1'b1);
        chk("reset_rdata", vif.rdata_o, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // full entry, then pop
        write_entry(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        chk("t1_rok", vif.rok_o, 1'b1);
        chk("t1_rdata", vif.rdata_o, 64'h4444_3333_2222_1111);
        cycle(0, 0, 16'h0, 1);
        chk("t1_pop_rok", vif.rok_o, 1'b0);

        // early close over a slot holding stale data
        write_entry(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        cycle(0, 0, 16'h0, 1);
        write_entry(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        cycle(0, 0, 16'h0, 1);
        cycle(1, 1, 16'hAAAA, 0);
        chk("t2_rdata", vif.rdata_o, 64'h0000_0000_0000_AAAA);
        cycle(0, 0, 16'h0, 1);

        // fill, writes ignored while full, pop reopens
        write_entry(16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04);
        write_entry(16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04);
        chk("t3_full_wok", vif.wok_o, 1'b0);
        cycle(1, 0, 16'hBEEF, 0);
        cycle(1, 0, 16'hBEEF, 0);
        cycle(1, 0, 16'hBEEF, 0);
        chk("t3_still_full", vif.wok_o, 1'b0);
        chk("t3_head_a", vif.rdata_o, 64'h0A04_0A03_0A02_0A01);
        cycle(0, 0, 16'h0, 1);
        chk("t3_wok_back", vif.wok_o, 1'b1);
        chk("t3_head_b", vif.rdata_o, 64'h0B04_0B03_0B02_0B01);
        cycle(0, 0, 16'h0, 1);

        // commit and pop on the same edge
        write_entry(16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04);
        cycle(1, 0, 16'h0D01, 0);
        cycle(1, 0, 16'h0D02, 0);
        cycle(1, 0, 16'h0D03, 0);
        cycle(1, 0, 16'h0D04, 1);
        chk("t4_rok", vif.rok_o, 1'b1);
        chk("t4_wok", vif.wok_o, 1'b1);
        chk("t4_rdata", vif.rdata_o, 64'h0D04_0D03_0D02_0D01);
        cycle(0, 0, 16'h0, 1);

        // async reset in the middle of a partial entry
        cycle(1, 0, 16'h0E01, 0);
        cycle(1, 0, 16'h0E02, 0);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_rok", vif.rok_o, 1'b0);
        chk("t5_rst_wok", vif.wok_o, 1'b1);
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        write_entry(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        chk("t5_rdata", vif.rdata_o, 64'h0004_0003_0002_0001);
        cycle(0, 0, 16'h0, 1);

        // randomized streams with stalls, pointer wrap at each depth
        stream(1);
        stream(3);
        stream(2);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
